// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared state type and defaults for the UART frame controller
package definitions_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        LAUNCH
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF     = 8'hA5;
    localparam int         TIMEOUT_TICKS_DEF = 2048;

endpackage

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - receives a synced, XOR-checked image frame over UART and launches processing
module uart_frame_ctrl
    import definitions_pkg::*;
#(
    parameter int         IMG_W         = 64,
    parameter int         IMG_H         = 64,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    localparam int        NPIX          = IMG_W * IMG_H,
    localparam int        ADDR_W        = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              s_tick,
    input  logic              proc_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              start_proc,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int                TMR_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_TICKS - 1);

    frame_state_t      state, state_nxt;
    logic [ADDR_W-1:0] count, count_nxt;
    logic [7:0]        csum, csum_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic              start_nxt;
    logic              err_nxt;
    logic              timer_hit;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= IDLE;
            count      <= '0;
            csum       <= '0;
            timer      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            start_proc <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            csum       <= csum_nxt;
            timer      <= timer_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            start_proc <= start_nxt;
            frame_err  <= err_nxt;
        end
    end

    // This tick would bring the timer to TIMEOUT_TICKS; a same-cycle byte takes precedence.
    assign timer_hit = s_tick && (timer == TMR_LAST);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        csum_nxt  = csum;
        timer_nxt = timer;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        start_nxt = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    state_nxt = PAYLOAD;
                    count_nxt = '0;
                    csum_nxt  = '0;
                    timer_nxt = '0;
                end
            end

            PAYLOAD: begin
                if (rx_done) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = count;
                    wdata_nxt = rx_data;
                    csum_nxt  = csum ^ rx_data;
                    timer_nxt = '0;
                    if (count == LAST_ADDR) begin
                        state_nxt = CHECK;
                    end else begin
                        count_nxt = count + ADDR_W'(1);
                    end
                end else if (timer_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (s_tick) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            CHECK: begin
                if (rx_done) begin
                    timer_nxt = '0;
                    if (rx_data == csum) begin
                        state_nxt = LAUNCH;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (timer_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (s_tick) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            LAUNCH: begin
                if (!proc_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign frame_done = start_proc;
    assign busy       = (state != IDLE);

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 64, image height in pixels.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 2048, maximum s_tick count allowed between bytes inside a frame.
REQ-005 SHALL have derived localparam NPIX = IMG_W*IMG_H and ADDR_W = $clog2(NPIX).
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rstN  input  1  synchronous, active-low reset.
REQ-008 rx_data  input  8  received byte from the UART receiver; valid only when rx_done=1.
REQ-009 rx_done  input  1  one-cycle strobe, one per received byte.
REQ-010 s_tick  input  1  baud oversample tick; used only as the timeout timebase.
REQ-011 proc_busy  input  1  edge-detection pipeline busy; blocks launch while high.
REQ-012 mem_we  output  1  image memory write enable, one-cycle pulse per pixel.
REQ-013 mem_addr  output  ADDR_W  image memory write address.
REQ-014 mem_wdata  output  8  image memory write data.
REQ-015 start_proc  output  1  one-cycle pulse that launches the pipeline.
REQ-016 frame_done  output  1  one-cycle pulse; frame accepted; coincident with start_proc.
REQ-017 frame_err  output  1  one-cycle pulse; frame aborted by checksum mismatch or timeout.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 Frame format SHALL be: SYNC_BYTE, then NPIX pixel bytes in raster order, then one checksum byte equal to the XOR of all pixel bytes.
REQ-020 States SHALL be IDLE, PAYLOAD, CHECK and LAUNCH.
REQ-021 IDLE: on an rx_done strobe with rx_data==SYNC_BYTE, the block SHALL go to PAYLOAD with pixel count=0, csum=0 and timer=0; all other bytes SHALL be discarded.
REQ-022 PAYLOAD: each rx_done strobe SHALL register mem_we=1, mem_wdata=rx_data and mem_addr=count on the next cycle (latency 1), then set csum^=rx_data and count+1.
REQ-023 PAYLOAD: the strobe that carries pixel NPIX-1 SHALL write that pixel and move the block to CHECK.
REQ-024 CHECK: the next rx_done strobe SHALL be compared with csum; on a match go to LAUNCH; on a mismatch pulse frame_err on the following cycle and go to IDLE.
REQ-025 LAUNCH: while proc_busy=1 the block SHALL hold; on the first cycle with proc_busy=0 it SHALL pulse start_proc and frame_done for one cycle and go to IDLE.
REQ-026 LAUNCH: rx_done strobes SHALL be ignored, including SYNC_BYTE.
REQ-027 Timer: in PAYLOAD and CHECK, each s_tick SHALL increment the timer and each rx_done strobe SHALL clear it.
REQ-028 When the timer reaches TIMEOUT_TICKS, the block SHALL pulse frame_err and go to IDLE; no further mem_we SHALL occur for that frame.
REQ-029 If rx_done and the terminal s_tick occur in the same cycle, rx_done SHALL win: the byte is processed and the timer cleared.
REQ-030 Outside a valid write cycle, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-031 The pixel counter SHALL never wrap; its maximum value is NPIX-1.
REQ-032 A SYNC_BYTE value inside PAYLOAD SHALL be treated as pixel data.

Reset
REQ-033 While rstN=0 at a clk edge, the block SHALL enter IDLE and clear count, csum and timer.
REQ-034 While rstN=0 at a clk edge, the block SHALL drive mem_we=0, mem_addr=0, mem_wdata=0, start_proc=0, frame_done=0, frame_err=0 and busy=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_err pulse.

Structure
REQ-036 The state enum (frame_state_t) and the SYNC_BYTE and TIMEOUT_TICKS defaults SHALL live in definitions_pkg.
REQ-037 The block SHALL have a single module with no sub-modules; the checksum and timer are inline registers.

Verification (IMG_W=4, IMG_H=2, TIMEOUT_TICKS=32)
REQ-038 Send A5, 01..08, then 08 -> eight mem_we pulses at addr 0..7 with data 01..08; start_proc and frame_done pulse once.
REQ-039 Send the same frame with checksum 09 -> frame_err pulses once, no start_proc, busy returns to 0.
REQ-040 Send 3C, 7E, then the valid frame -> the first two bytes are ignored and the frame completes normally.
REQ-041 Send A5, 01, 02, then 40 s_ticks with no byte -> frame_err is pulsed after the 32nd tick, only 2 writes occur, and the state is IDLE.
REQ-042 Send a valid frame with proc_busy=1 held for 20 cycles -> start_proc is pulsed on the first cycle proc_busy=0, and an A5 sent during the hold is ignored.
REQ-043 Assert rstN=0 after the 4th pixel, then send a valid frame -> no frame_err, writes restart at addr 0, and the frame completes.
